// File: rtl/uart_rx_frame_check.sv
// Frame-aware UART RX checker: tracks data/parity/stop bits and flags parity and framing errors.
// Optional saturating parity-error counter enabled by `define PARITY_ERR_CNT_EN.
module uart_rx_frame_check #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 8,
   localparam int unsigned LEN_WIDTH = $clog2(DATA_WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  bit_valid,
   input  logic                  bit_in,
   input  logic                  par_en,
   input  logic [1:0]            par_typ,
   input  logic [LEN_WIDTH-1:0]  data_len,
   input  logic                  cnt_clr,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  frame_done,
   output logic                  par_err,
   output logic                  stp_err,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  err_cnt
);

   localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t                  state, state_nxt;
   logic                    load, shift_en, par_cap, stop_cap;
   logic                    last_bit, exp_par;
   logic [LEN_WIDTH-1:0]    eff_len, len_q, bit_cnt;
   logic [DATA_WIDTH-1:0]   shift_q;
   logic                    acc, par_en_q, par_bad_q;
   logic [1:0]              par_typ_q;

   // Out-of-range lengths (0 or above DATA_WIDTH) mean a full-width frame
   assign eff_len  = (data_len == '0 || data_len > MAX_LEN) ? MAX_LEN : data_len;
   assign last_bit = (bit_cnt == len_q - LEN_WIDTH'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // start always wins: it aborts any frame in flight and restarts at DATA
   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = DATA;
      end else if (bit_valid) begin
         case (state)
            IDLE:    state_nxt = IDLE;
            DATA:    if (last_bit) state_nxt = par_en_q ? PARITY : STOP;
            PARITY:  state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      load     = start;
      shift_en = 1'b0;
      par_cap  = 1'b0;
      stop_cap = 1'b0;
      if (!start && bit_valid) begin
         case (state)
            DATA:    shift_en = 1'b1;
            PARITY:  par_cap  = 1'b1;
            STOP:    stop_cap = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      case (par_typ_q)
         2'b00:   exp_par = acc;
         2'b01:   exp_par = ~acc;
         2'b10:   exp_par = 1'b1;
         default: exp_par = 1'b0;
      endcase
   end

   // Frame datapath: shadow config, bit placement by index keeps data right-aligned
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_q     <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 2'b00;
         bit_cnt   <= '0;
         shift_q   <= '0;
         acc       <= 1'b0;
         par_bad_q <= 1'b0;
      end else if (load) begin
         len_q     <= eff_len;
         par_en_q  <= par_en;
         par_typ_q <= par_typ;
         bit_cnt   <= '0;
         shift_q   <= '0;
         acc       <= 1'b0;
         par_bad_q <= 1'b0;
      end else if (shift_en) begin
         shift_q <= shift_q | (DATA_WIDTH'(bit_in) << bit_cnt);
         acc     <= acc ^ bit_in;
         if (!last_bit) bit_cnt <= bit_cnt + LEN_WIDTH'(1);
      end else if (par_cap) begin
         par_bad_q <= (bit_in != exp_par);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_done <= 1'b0;
         data_out   <= '0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         frame_done <= stop_cap;
         busy       <= (state_nxt != IDLE);
         if (stop_cap) begin
            data_out <= shift_q;
            par_err  <= par_en_q & par_bad_q;
            stp_err  <= ~bit_in;
         end
      end
   end

`ifdef PARITY_ERR_CNT_EN
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   // Counts on the frame_done cycle so a simultaneous clear takes priority
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         err_cnt <= '0;
      else if (cnt_clr)
         err_cnt <= '0;
      else if (frame_done && par_err && err_cnt != CNT_MAX)
         err_cnt <= err_cnt + CNT_WIDTH'(1);
   end
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Bench for uart_rx_frame_check: table of frames plus hand-built abort/reset/clear sequences,
// frame results checked through a scoreboard queue popped on frame_done.
module tb_uart_rx_frame_check;

   localparam int unsigned DW = 8;
   localparam int unsigned CW = 2;
   localparam int unsigned LW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0, bit_valid = 1'b0, bit_in = 1'b0, par_en = 1'b0, cnt_clr = 1'b0;
   logic [1:0]    par_typ = 2'b00;
   logic [LW-1:0] data_len = '0;
   logic [DW-1:0] data_out;
   logic          frame_done, par_err, stp_err, busy;
   logic [CW-1:0] err_cnt;

   uart_rx_frame_check #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
      .par_en(par_en), .par_typ(par_typ), .data_len(data_len), .cnt_clr(cnt_clr),
      .data_out(data_out), .frame_done(frame_done), .par_err(par_err), .stp_err(stp_err),
      .busy(busy), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic          pe;
      logic          se;
   } exp_t;

   typedef struct {
      logic [LW-1:0] len;
      logic          pe;
      logic [1:0]    pt;
      logic [DW-1:0] data;
      logic          pbit;
      logic          sbit;
      logic [DW-1:0] x_data;
      logic          x_pe;
      logic          x_se;
   } vec_t;

   int            n_cmp = 0;
   int            n_bad = 0;
   int            n_done = 0;
   int            n_exp = 0;
   exp_t          sb[$];
   exp_t          mon_e;
   vec_t          vecs[10];
   vec_t          v_tmp;
   logic [CW-1:0] exp_cnt = '0;
   int            done_before;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic b);
      bit_valid = 1'b1;
      bit_in    = b;
      tick();
      bit_valid = 1'b0;
   endtask

   // Drives one full frame; dirty=1 also raises bit_valid with start (that bit must be dropped)
   task automatic send_frame(input vec_t v, input logic clr, input logic dirty);
      int   nb;
      exp_t e;
      nb = (v.len == '0 || v.len > LW'(DW)) ? DW : int'(v.len);
      start = 1'b1; data_len = v.len; par_en = v.pe; par_typ = v.pt;
      if (dirty) begin bit_valid = 1'b1; bit_in = 1'b1; end
      tick();
      start = 1'b0; bit_valid = 1'b0;
      check("busy_after_start", busy, 1);
      data_len = ~v.len; par_en = ~v.pe; par_typ = ~v.pt;
      for (int i = 0; i < nb; i++) begin
         strobe(v.data[i]);
         if (i % 3 == 1) tick();
      end
      if (v.pe) strobe(v.pbit);
      e.data = v.x_data; e.pe = v.x_pe; e.se = v.x_se;
      sb.push_back(e);
      n_exp++;
      strobe(v.sbit);
      check("done_latency", frame_done, 1);
      check("busy_after_stop", busy, 0);
      cnt_clr = clr;
`ifdef PARITY_ERR_CNT_EN
      if (clr) exp_cnt = '0;
      else if (v.x_pe && exp_cnt != '1) exp_cnt = exp_cnt + CW'(1);
`else
      exp_cnt = '0;
`endif
      tick();
      cnt_clr = 1'b0;
      check("done_single_pulse", frame_done, 0);
      check("err_cnt", err_cnt, exp_cnt);
   endtask

   // Scoreboard: every frame_done pops the oldest expected frame
   always @(negedge clk) begin
      if (frame_done === 1'b1) begin
         n_done++;
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame_done: got data 0x%0h with empty queue", data_out);
         end else begin
            mon_e = sb.pop_front();
            check("data_out", data_out, mon_e.data);
            check("par_err", par_err, mon_e.pe);
            check("stp_err", stp_err, mon_e.se);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //            len   pe    pt    data   pbit  sbit  x_data x_pe  x_se
      vecs[0] = '{4'd8,  1'b0, 2'd0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{4'd8,  1'b1, 2'd0, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
      vecs[2] = '{4'd8,  1'b1, 2'd0, 8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
      vecs[3] = '{4'd5,  1'b1, 2'd1, 8'h1F, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0};
      vecs[4] = '{4'd5,  1'b1, 2'd2, 8'h1F, 1'b0, 1'b1, 8'h1F, 1'b1, 1'b0};
      vecs[5] = '{4'd0,  1'b0, 2'd0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
      vecs[6] = '{4'd15, 1'b1, 2'd3, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[7] = '{4'd1,  1'b1, 2'd1, 8'hFF, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
      vecs[8] = '{4'd3,  1'b1, 2'd0, 8'hFD, 1'b0, 1'b0, 8'h05, 1'b0, 1'b1};
      vecs[9] = '{4'd8,  1'b1, 2'd1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};

      tick(); tick();
      check("rst_data_out", data_out, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_par_err", par_err, 0);
      check("rst_stp_err", stp_err, 0);
      check("rst_busy", busy, 0);
      check("rst_err_cnt", err_cnt, 0);
      #3 rst = 1'b1;
      tick();

      // Strobes while idle are ignored
      for (int i = 0; i < 3; i++) strobe(1'b1);
      check("idle_busy", busy, 0);
      check("idle_done_count", n_done, 0);

      for (int i = 0; i < 10; i++) send_frame(vecs[i], 1'b0, 1'b0);

      // Fifth parity-error frame: counter stays saturated
      send_frame(vecs[2], 1'b0, 1'b0);
      // Clear coinciding with a parity-error frame_done
      send_frame(vecs[2], 1'b1, 1'b0);

      // Abort after 3 bits, then a full 0x3C frame: one frame_done only
      done_before = n_done;
      start = 1'b1; data_len = 4'd8; par_en = 1'b0; tick(); start = 1'b0;
      strobe(1'b1); strobe(1'b1); strobe(1'b0);
      v_tmp = '{4'd8, 1'b0, 2'd0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
      send_frame(v_tmp, 1'b0, 1'b0);
      check("abort_done_count", n_done - done_before, 1);

      // bit_valid together with start: the bit is discarded
      v_tmp = '{4'd8, 1'b0, 2'd0, 8'h02, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0};
      send_frame(v_tmp, 1'b0, 1'b1);

      // Leave outputs and counter non-zero, then reset asynchronously mid-frame
      send_frame(vecs[4], 1'b0, 1'b0);
      start = 1'b1; data_len = 4'd8; par_en = 1'b1; tick(); start = 1'b0;
      strobe(1'b1); strobe(1'b0);
      #3 rst = 1'b0;
      #1;
      check("arst_data_out", data_out, 0);
      check("arst_par_err", par_err, 0);
      check("arst_stp_err", stp_err, 0);
      check("arst_frame_done", frame_done, 0);
      check("arst_busy", busy, 0);
      check("arst_err_cnt", err_cnt, 0);
      exp_cnt = '0;
      #2 rst = 1'b1;
      tick();
      send_frame(vecs[0], 1'b0, 1'b0);

      tick(); tick();
      check("scoreboard_empty", sb.size(), 0);
      check("total_done_count", n_done, n_exp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
